// File: rtl/l1_trigger_event_builder.sv
// l1_trigger_event_builder
// Merges per-beam L1 triggers that fall inside a short coincidence window into
// one event, stamps it with a free-running counter, then holds off for a global
// dead time. Events queue in a first-word-fall-through FIFO and stream out as
// {timestamp, beam_mask} on a valid/ready interface.
module l1_trigger_event_builder #(
  parameter int NBEAMS          = 2,
  parameter int TS_BITS         = 32,
  parameter int WINDOW_CLOCKS   = 4,
  parameter int DEADTIME_CLOCKS = 16,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          enable_i,
  input  logic [NBEAMS-1:0]             trigger_i,
  input  logic [NBEAMS-1:0]             mask_i,
  output logic [TS_BITS+NBEAMS-1:0]     m_tdata_o,
  output logic                          m_tvalid_o,
  input  logic                          m_tready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic [15:0]                   dropped_o
);

  localparam int DW      = TS_BITS + NBEAMS;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int CNT_MAX = (WINDOW_CLOCKS > DEADTIME_CLOCKS) ? WINDOW_CLOCKS : DEADTIME_CLOCKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // The window spans WINDOW_CLOCKS cycles including the triggering cycle, so
  // GATHER lasts WINDOW_CLOCKS-1 cycles and its counter starts at W-2.
  localparam logic [CNT_W-1:0] WIN_LOAD  = CNT_W'((WINDOW_CLOCKS > 1) ? WINDOW_CLOCKS - 2 : 0);
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEADTIME_CLOCKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_GATHER, S_DEAD} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TS_BITS-1:0]  ts_q, ts_d;
  logic [TS_BITS-1:0]  ev_ts_q, ev_ts_d;
  logic [NBEAMS-1:0]   ev_mask_q, ev_mask_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [15:0]         dropped_q, dropped_d;
  logic [DW-1:0]       mem_q [FIFO_DEPTH];

  logic [NBEAMS-1:0]   hit;
  logic                push, push_ok, pop, full;
  logic [DW-1:0]       push_data;

  assign hit = trigger_i & ~mask_i;

  // Event FSM: open a window on the first hit, OR in later hits, push, hold off.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ev_ts_d   = ev_ts_q;
    ev_mask_d = ev_mask_q;
    push      = 1'b0;
    push_data = {ev_ts_q, ev_mask_q | hit};
    case (state_q)
      S_IDLE: begin
        if (enable_i && (|hit)) begin
          ev_ts_d   = ts_q;
          ev_mask_d = hit;
          if (WINDOW_CLOCKS == 1) begin
            push      = 1'b1;
            push_data = {ts_q, hit};
            state_d   = S_DEAD;
            cnt_d     = DEAD_LOAD;
          end else begin
            state_d = S_GATHER;
            cnt_d   = WIN_LOAD;
          end
        end
      end
      S_GATHER: begin
        ev_mask_d = ev_mask_q | hit;
        if (cnt_q == '0) begin
          push    = 1'b1;
          state_d = S_DEAD;
          cnt_d   = DEAD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DEAD: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping: a push into a full FIFO still lands if the head pops this cycle.
  always_comb begin
    full     = (count_q == CW'(FIFO_DEPTH));
    pop      = (count_q != '0) && m_tready_i;
    push_ok  = push && (!full || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    dropped_d = dropped_q;
    if (push && !push_ok && (dropped_q != 16'hFFFF)) dropped_d = dropped_q + 16'd1;
    ts_d = ts_q + TS_BITS'(1);
  end

  // Control state, timestamp and FIFO pointers; reset discards any open event.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ts_q      <= '0;
      ev_ts_q   <= '0;
      ev_mask_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ts_q      <= ts_d;
      ev_ts_q   <= ev_ts_d;
      ev_mask_q <= ev_mask_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
    end
  end

  // Event storage; contents are don't-care until counted, so no reset.
  always_ff @(posedge aclk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign m_tvalid_o   = (count_q != '0);
  assign m_tdata_o    = m_tvalid_o ? mem_q[rd_ptr_q] : '0;
  assign fifo_count_o = count_q;
  assign dropped_o    = dropped_q;

endmodule

// File: tb/tb_l1_trigger_event_builder.sv
// Directed bench for l1_trigger_event_builder: a default (32-bit timestamp)
// instance for window/dead-time/FIFO behaviour and an 8-bit-timestamp
// instance for wrap and mid-event reset.
module tb_l1_trigger_event_builder;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;

  logic        en, rdy;
  logic [1:0]  trig, msk;
  logic [33:0] tdata;
  logic        tvalid;
  logic [4:0]  count;
  logic [15:0] dropped;

  logic        en8, rdy8;
  logic [1:0]  trig8, msk8;
  logic [9:0]  tdata8;
  logic        tvalid8;
  logic [4:0]  count8;
  logic [15:0] dropped8;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  l1_trigger_event_builder u_dut (
    .aclk(aclk), .aresetn(aresetn), .enable_i(en), .trigger_i(trig), .mask_i(msk),
    .m_tdata_o(tdata), .m_tvalid_o(tvalid), .m_tready_i(rdy),
    .fifo_count_o(count), .dropped_o(dropped)
  );

  l1_trigger_event_builder #(.TS_BITS(8)) u_dut8 (
    .aclk(aclk), .aresetn(aresetn), .enable_i(en8), .trigger_i(trig8), .mask_i(msk8),
    .m_tdata_o(tdata8), .m_tvalid_o(tvalid8), .m_tready_i(rdy8),
    .fifo_count_o(count8), .dropped_o(dropped8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  // Drive trigger pattern v during exactly cycle c (cycle == timestamp value).
  task automatic pulse(input int c, input logic [1:0] v);
    goto(c);
    trig = v;
    tick();
    trig = 2'b00;
  endtask

  task automatic pulse8(input int c, input logic [1:0] v);
    goto(c);
    trig8 = v;
    tick();
    trig8 = 2'b00;
  endtask

  // Hold reset two clocks, release just after a posedge: that cycle is ts=0.
  task automatic do_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    cyc = 0;
  endtask

  initial begin
    en = 1'b1; rdy = 1'b0; trig = '0; msk = '0;
    en8 = 1'b1; rdy8 = 1'b0; trig8 = '0; msk8 = '0;

    // Reset state
    #12;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_dropped", 64'(dropped), 64'd0);

    // 1: single beam-0 trigger at ts=100, consumer ready
    do_reset();
    rdy = 1'b1;
    pulse(100, 2'b01);
    goto(103);
    chk("t1_not_yet", 64'(tvalid), 64'd0);
    goto(104);
    chk("t1_tvalid", 64'(tvalid), 64'd1);
    chk("t1_tdata", 64'(tdata), 64'({32'd100, 2'b01}));
    chk("t1_count", 64'(count), 64'd1);
    goto(105);
    chk("t1_count_after_pop", 64'(count), 64'd0);
    chk("t1_tvalid_after_pop", 64'(tvalid), 64'd0);

    // 2: hits inside the window merge; hit in first dead cycle ignored
    do_reset();
    rdy = 1'b0;
    pulse(100, 2'b01);
    pulse(103, 2'b10);
    chk("t2_tvalid", 64'(tvalid), 64'd1);
    chk("t2_tdata", 64'(tdata), 64'({32'd100, 2'b11}));
    pulse(104, 2'b10);
    goto(130);
    chk("t2_count", 64'(count), 64'd1);
    chk("t2_head", 64'(tdata), 64'({32'd100, 2'b11}));

    // 3: trigger during dead time ignored, trigger on first idle cycle accepted
    do_reset();
    rdy = 1'b0;
    pulse(100, 2'b01);
    pulse(110, 2'b01);
    pulse(120, 2'b01);
    goto(130);
    chk("t3_count", 64'(count), 64'd2);
    chk("t3_head0", 64'(tdata), 64'({32'd100, 2'b01}));
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("t3_head1", 64'(tdata), 64'({32'd120, 2'b01}));
    chk("t3_count_after_pop", 64'(count), 64'd1);

    // 4: 20 back-to-back events into a stalled 16-deep FIFO
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 20; i++) pulse(100 + 20 * i, 2'b01);
    goto(485);
    chk("t4_count_full", 64'(count), 64'd16);
    chk("t4_dropped", 64'(dropped), 64'd4);
    rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t4_drain%0d_vld", i), 64'(tvalid), 64'd1);
      chk($sformatf("t4_drain%0d", i), 64'(tdata), 64'({32'(100 + 20 * i), 2'b01}));
      tick();
    end
    chk("t4_empty", 64'(count), 64'd0);
    chk("t4_tvalid_empty", 64'(tvalid), 64'd0);
    rdy = 1'b0;

    // 5: masking and enable
    do_reset();
    rdy = 1'b0;
    msk = 2'b01;
    pulse(100, 2'b01);
    goto(130);
    chk("t5_masked_none", 64'(count), 64'd0);
    pulse(130, 2'b11);
    goto(140);
    chk("t5_count", 64'(count), 64'd1);
    chk("t5_tdata", 64'(tdata), 64'({32'd130, 2'b10}));
    en = 1'b0;
    pulse(160, 2'b11);
    goto(170);
    chk("t5_disabled", 64'(count), 64'd1);
    en = 1'b1;
    msk = 2'b00;

    // 6: 8-bit timestamp wrap, then reset during GATHER
    do_reset();
    rdy8 = 1'b0;
    pulse8(255, 2'b01);
    goto(259);
    chk("t6_tvalid", 64'(tvalid8), 64'd1);
    goto(260);
    chk("t6_stamp255", 64'(tdata8), 64'({8'd255, 2'b01}));
    chk("t6_count", 64'(count8), 64'd1);
    pulse8(275, 2'b01);
    goto(280);
    rdy8 = 1'b1;
    tick();
    rdy8 = 1'b0;
    chk("t6_wrapped_stamp", 64'(tdata8), 64'({8'd19, 2'b01}));
    chk("t6_count2", 64'(count8), 64'd1);
    pulse8(300, 2'b01);
    tick();
    aresetn = 1'b0;
    #1;
    chk("t6_rst_tvalid", 64'(tvalid8), 64'd0);
    chk("t6_rst_count", 64'(count8), 64'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    cyc = 0;
    goto(30);
    chk("t6_no_stale_count", 64'(count8), 64'd0);
    chk("t6_no_stale_tvalid", 64'(tvalid8), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
